// File: rtl/usb_rx_pkg.sv
// Shared PID constants, packet-class encoding and receive FSM state encoding
// for the USB receive packet controller.
package usb_rx_pkg;

    localparam logic [7:0] PID_OUT   = 8'h1E;
    localparam logic [7:0] PID_IN    = 8'h96;
    localparam logic [7:0] PID_DATA0 = 8'h3C;
    localparam logic [7:0] PID_DATA1 = 8'hB4;
    localparam logic [7:0] PID_ACK   = 8'h2D;
    localparam logic [7:0] PID_NAK   = 8'hA5;
    localparam logic [7:0] PID_STALL = 8'hE1;

    typedef enum logic [2:0] {
        RX_ACK   = 3'b000,
        RX_OUT   = 3'b001,
        RX_IN    = 3'b010,
        RX_ERR   = 3'b011,
        RX_DATA  = 3'b100,
        RX_NAK   = 3'b101,
        RX_STALL = 3'b110
    } rx_class_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PID      = 3'd1,
        ST_TOKEN1   = 3'd2,
        ST_TOKEN2   = 3'd3,
        ST_TOK_EOP  = 3'd4,
        ST_HSK_EOP  = 3'd5,
        ST_DATA     = 3'd6,
        ST_ERR_WAIT = 3'd7
    } rx_state_t;

    // A PID byte carries its own check nibble: the upper half is the inverse of the lower.
    function automatic logic pid_check(input logic [7:0] pid);
        return (pid[7:4] == ~pid[3:0]);
    endfunction

endpackage

// File: rtl/rx_packet_ctrl_delay.sv
// Two-entry byte delay line used to hold back the trailing CRC16 bytes of a
// DATA packet; out presents the oldest entry whenever the line is full.
module rx_byte_delay (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       push,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] out,
    output logic       out_valid,
    output logic [1:0] level
);

    logic [7:0] slot0_r;
    logic [7:0] slot1_r;
    logic [1:0] level_r;

    // Delay-line storage: fill oldest-first, then shift once full.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            slot0_r <= 8'h00;
            slot1_r <= 8'h00;
            level_r <= 2'd0;
        end else if (flush) begin
            slot0_r <= 8'h00;
            slot1_r <= 8'h00;
            level_r <= 2'd0;
        end else if (push) begin
            case (level_r)
                2'd0: begin
                    slot0_r <= din;
                    level_r <= 2'd1;
                end
                2'd1: begin
                    slot1_r <= din;
                    level_r <= 2'd2;
                end
                default: begin
                    slot0_r <= slot1_r;
                    slot1_r <= din;
                    level_r <= 2'd2;
                end
            endcase
        end
    end

    assign out       = slot0_r;
    assign out_valid = (level_r == 2'd2);
    assign level     = level_r;

endmodule

// File: rtl/rx_packet_ctrl.sv
// USB receive packet controller: decodes the PID, tracks token/handshake/data
// packet framing and streams DATA payload bytes to the FIFO minus the CRC16.
module rx_packet_ctrl
    import usb_rx_pkg::*;
#(
    parameter  int MAX_PAYLOAD = 64,
    localparam int CNT_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             sync_byte,
    input  logic             byte_valid,
    input  logic [7:0]       packet_in,
    input  logic             eop,
    input  logic             crc5_ok,
    input  logic             crc16_ok,
    output logic             crc_clear,
    output logic [2:0]       rx_packet,
    output logic [7:0]       rx_data,
    output logic             store_rx_data,
    output logic [CNT_W-1:0] rx_data_count,
    output logic             rx_done
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAYLOAD);

    rx_state_t        state_r, state_n;
    rx_class_t        pkt_r, pkt_n;
    logic [7:0]       data_r, data_n;
    logic [CNT_W-1:0] count_r, count_n;
    logic             clr_r, clr_n;
    logic             store_r, store_n;
    logic             done_r, done_n;
    logic             push_s;
    logic [1:0]       lvl_after_s;
    logic [7:0]       buf_out_s;
    logic             buf_full_s;
    logic [1:0]       buf_level_s;

    rx_byte_delay u_delay (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push_s),
        .flush     (sync_byte),
        .din       (packet_in),
        .out       (buf_out_s),
        .out_valid (buf_full_s),
        .level     (buf_level_s)
    );

    // Next-state/output logic: the byte is applied first, then eop is judged on the result.
    always_comb begin
        state_n     = state_r;
        pkt_n       = pkt_r;
        data_n      = data_r;
        count_n     = count_r;
        clr_n       = 1'b0;
        store_n     = 1'b0;
        done_n      = 1'b0;
        push_s      = 1'b0;
        lvl_after_s = buf_level_s;
        if (sync_byte) begin
            state_n = ST_PID;
            pkt_n   = RX_ACK;
            count_n = '0;
            clr_n   = 1'b1;
        end else begin
            if (byte_valid) begin
                case (state_r)
                    ST_PID: begin
                        state_n = ST_ERR_WAIT;
                        pkt_n   = RX_ERR;
                        if (pid_check(packet_in)) begin
                            case (packet_in)
                                PID_DATA0, PID_DATA1: begin state_n = ST_DATA;    pkt_n = RX_DATA;  end
                                PID_OUT:              begin state_n = ST_TOKEN1;  pkt_n = RX_OUT;   end
                                PID_IN:               begin state_n = ST_TOKEN1;  pkt_n = RX_IN;    end
                                PID_ACK:              begin state_n = ST_HSK_EOP; pkt_n = RX_ACK;   end
                                PID_NAK:              begin state_n = ST_HSK_EOP; pkt_n = RX_NAK;   end
                                PID_STALL:            begin state_n = ST_HSK_EOP; pkt_n = RX_STALL; end
                                default:              begin state_n = ST_ERR_WAIT; pkt_n = RX_ERR;  end
                            endcase
                        end else begin
                            state_n = ST_ERR_WAIT;
                        end
                    end
                    ST_TOKEN1: state_n = ST_TOKEN2;
                    ST_TOKEN2: state_n = ST_TOK_EOP;
                    ST_TOK_EOP, ST_HSK_EOP: begin
                        state_n = ST_ERR_WAIT;
                        pkt_n   = RX_ERR;
                        done_n  = 1'b1;
                    end
                    ST_DATA: begin
                        if (buf_full_s && (count_r == MAX_CNT)) begin
                            state_n = ST_ERR_WAIT;
                            pkt_n   = RX_ERR;
                        end else begin
                            push_s      = 1'b1;
                            store_n     = buf_full_s;
                            data_n      = buf_full_s ? buf_out_s : data_r;
                            count_n     = buf_full_s ? (count_r + CNT_W'(1)) : count_r;
                            lvl_after_s = buf_full_s ? 2'd2 : (buf_level_s + 2'd1);
                        end
                    end
                    default: state_n = state_r;
                endcase
            end else begin
                state_n = state_r;
            end
            if (eop) begin
                case (state_n)
                    ST_PID, ST_TOKEN1, ST_TOKEN2: begin
                        pkt_n   = RX_ERR;
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                    ST_TOK_EOP: begin
                        pkt_n   = crc5_ok ? pkt_n : RX_ERR;
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                    ST_DATA: begin
                        pkt_n   = ((lvl_after_s == 2'd2) && crc16_ok) ? pkt_n : RX_ERR;
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                    ST_HSK_EOP, ST_ERR_WAIT: begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                    default: state_n = state_n;
                endcase
            end else begin
                done_n = done_n;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
            pkt_r   <= RX_ACK;
            data_r  <= 8'h00;
            count_r <= '0;
            clr_r   <= 1'b0;
            store_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            pkt_r   <= pkt_n;
            data_r  <= data_n;
            count_r <= count_n;
            clr_r   <= clr_n;
            store_r <= store_n;
            done_r  <= done_n;
        end
    end

    assign crc_clear     = clr_r;
    assign rx_packet     = pkt_r;
    assign rx_data       = data_r;
    assign store_rx_data = store_r;
    assign rx_data_count = count_r;
    assign rx_done       = done_r;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Scoreboard bench: two controllers (MAX_PAYLOAD 64 and 2) see the same directed
// packets; a negedge monitor pops expected stores/completions per instance.
module tb_rx_packet_ctrl;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic sync_byte = 1'b0, byte_valid = 1'b0, eop = 1'b0, crc5_ok = 1'b0, crc16_ok = 1'b0;
    logic [7:0] packet_in = 8'h00;

    logic       clr0, st0, dn0, clr1, st1, dn1;
    logic [2:0] pk0, pk1;
    logic [7:0] d0, d1;
    logic [6:0] cnt0;
    logic [1:0] cnt1;

    int checks = 0;
    int failures = 0;
    int syncs = 0;
    int clr_seen [2];
    logic [7:0] exp_store [2][$];
    logic [2:0] exp_pkt [2][$];
    int         exp_cnt [2][$];

    always #5 clk = ~clk;

    rx_packet_ctrl #(.MAX_PAYLOAD(64)) dut0 (
        .clk(clk), .n_rst(n_rst), .sync_byte(sync_byte), .byte_valid(byte_valid),
        .packet_in(packet_in), .eop(eop), .crc5_ok(crc5_ok), .crc16_ok(crc16_ok),
        .crc_clear(clr0), .rx_packet(pk0), .rx_data(d0), .store_rx_data(st0),
        .rx_data_count(cnt0), .rx_done(dn0)
    );

    rx_packet_ctrl #(.MAX_PAYLOAD(2)) dut1 (
        .clk(clk), .n_rst(n_rst), .sync_byte(sync_byte), .byte_valid(byte_valid),
        .packet_in(packet_in), .eop(eop), .crc5_ok(crc5_ok), .crc16_ok(crc16_ok),
        .crc_clear(clr1), .rx_packet(pk1), .rx_data(d1), .store_rx_data(st1),
        .rx_data_count(cnt1), .rx_done(dn1)
    );

    task automatic check(input string name, input int i, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s dut%0d actual=0x%0h required=0x%0h", name, i, act, req);
        end
    endtask

    task automatic mon(input int i, input logic st, input logic [7:0] d, input logic dn,
                       input logic [2:0] pk, input int cnt, input logic clr);
        if (clr) clr_seen[i]++;
        if (st) begin
            if (exp_store[i].size() == 0) check("unexpected_store", i, 1, 0);
            else check("store_data", i, int'(d), int'(exp_store[i].pop_front()));
        end
        if (dn) begin
            if (exp_pkt[i].size() == 0) check("unexpected_done", i, 1, 0);
            else begin
                check("done_rx_packet", i, int'(pk), int'(exp_pkt[i].pop_front()));
                check("done_count", i, cnt, exp_cnt[i].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, st0, d0, dn0, pk0, int'(cnt0), clr0);
        mon(1, st1, d1, dn1, pk1, int'(cnt1), clr1);
    end

    task automatic step(input logic s, input logic bv, input logic [7:0] b,
                        input logic e, input logic c5, input logic c16);
        sync_byte = s; byte_valid = bv; packet_in = b; eop = e; crc5_ok = c5; crc16_ok = c16;
        @(posedge clk); #1;
        sync_byte = 1'b0; byte_valid = 1'b0; eop = 1'b0; crc5_ok = 1'b0; crc16_ok = 1'b0;
    endtask

    task automatic do_sync();
        syncs++;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic end_pkt(input logic c5, input logic c16);
        step(1'b0, 1'b0, 8'h00, 1'b1, c5, c16);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exp_done(input int i, input logic [2:0] pk, input int cnt);
        exp_pkt[i].push_back(pk);
        exp_cnt[i].push_back(cnt);
    endtask

    task automatic hold_check(input logic [2:0] p0, input int c0, input logic [2:0] p1, input int c1);
        idle(2);
        check("hold_rx_packet", 0, int'(pk0), int'(p0));
        check("hold_count", 0, int'(cnt0), c0);
        check("hold_rx_packet", 1, int'(pk1), int'(p1));
        check("hold_count", 1, int'(cnt1), c1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 0, int'({pk0, d0, cnt0, st0, dn0, clr0}), 0);
        check("reset_outputs", 1, int'({pk1, d1, cnt1, st1, dn1, clr1}), 0);
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;

        // OUT token, good CRC5
        exp_done(0, 3'b001, 0); exp_done(1, 3'b001, 0);
        do_sync(); send(8'h1E); send(8'h05); send(8'hA8); end_pkt(1'b1, 1'b0);
        hold_check(3'b001, 0, 3'b001, 0);

        // IN token, bad CRC5
        exp_done(0, 3'b011, 0); exp_done(1, 3'b011, 0);
        do_sync(); send(8'h96); send(8'h01); send(8'h02); end_pkt(1'b0, 1'b0);

        // DATA0 with three payload bytes; the small instance overflows on the last push
        exp_store[0].push_back(8'h11); exp_store[0].push_back(8'h22); exp_store[0].push_back(8'h33);
        exp_store[1].push_back(8'h11); exp_store[1].push_back(8'h22);
        exp_done(0, 3'b100, 3); exp_done(1, 3'b011, 2);
        do_sync(); send(8'h3C); send(8'h11); send(8'h22); send(8'h33); send(8'hC1); send(8'hC2);
        end_pkt(1'b0, 1'b1);
        hold_check(3'b100, 3, 3'b011, 2);

        // DATA1 overflow scenario
        exp_store[0].push_back(8'h01); exp_store[0].push_back(8'h02); exp_store[0].push_back(8'h03);
        exp_store[1].push_back(8'h01); exp_store[1].push_back(8'h02);
        exp_done(0, 3'b100, 3); exp_done(1, 3'b011, 2);
        do_sync(); send(8'hB4); send(8'h01); send(8'h02); send(8'h03); send(8'hC1); send(8'hC2);
        idle(2);
        end_pkt(1'b0, 1'b1);

        // malformed PID, trailing bytes ignored
        exp_done(0, 3'b011, 0); exp_done(1, 3'b011, 0);
        do_sync(); send(8'h3D); send(8'h11); send(8'h22); end_pkt(1'b0, 1'b1);
        hold_check(3'b011, 0, 3'b011, 0);

        // resync in the middle of a DATA packet, then ACK
        exp_done(0, 3'b000, 0); exp_done(1, 3'b000, 0);
        do_sync(); send(8'h3C); send(8'hAA); do_sync(); send(8'h2D); end_pkt(1'b0, 1'b0);
        hold_check(3'b000, 0, 3'b000, 0);

        // NAK and STALL handshakes
        exp_done(0, 3'b101, 0); exp_done(1, 3'b101, 0);
        do_sync(); send(8'hA5); end_pkt(1'b0, 1'b0);
        exp_done(0, 3'b110, 0); exp_done(1, 3'b110, 0);
        do_sync(); send(8'hE1); end_pkt(1'b0, 1'b0);

        // DATA with only one byte before eop
        exp_done(0, 3'b011, 0); exp_done(1, 3'b011, 0);
        do_sync(); send(8'h3C); send(8'hC1); end_pkt(1'b0, 1'b1);

        // DATA with bad CRC16
        exp_store[0].push_back(8'h11); exp_store[1].push_back(8'h11);
        exp_done(0, 3'b011, 1); exp_done(1, 3'b011, 1);
        do_sync(); send(8'h3C); send(8'h11); send(8'hC1); send(8'hC2); end_pkt(1'b0, 1'b0);

        // byte and eop in the same cycle: ACK PID, and last CRC byte of DATA
        exp_done(0, 3'b000, 0); exp_done(1, 3'b000, 0);
        do_sync(); step(1'b0, 1'b1, 8'h2D, 1'b1, 1'b0, 1'b0);
        exp_store[0].push_back(8'h55); exp_store[1].push_back(8'h55);
        exp_done(0, 3'b100, 1); exp_done(1, 3'b100, 1);
        do_sync(); send(8'h3C); send(8'h55); send(8'hC1); step(1'b0, 1'b1, 8'hC2, 1'b1, 1'b0, 1'b1);
        hold_check(3'b100, 1, 3'b100, 1);

        // eop too early in a token; well-formed but unknown PID
        exp_done(0, 3'b011, 0); exp_done(1, 3'b011, 0);
        do_sync(); send(8'h1E); end_pkt(1'b1, 1'b0);
        exp_done(0, 3'b011, 0); exp_done(1, 3'b011, 0);
        do_sync(); send(8'h0F); send(8'h12); end_pkt(1'b1, 1'b1);

        // extra byte after a handshake: immediate done, then done again at eop
        exp_done(0, 3'b011, 0); exp_done(1, 3'b011, 0);
        exp_done(0, 3'b011, 0); exp_done(1, 3'b011, 0);
        do_sync(); send(8'h2D); send(8'h77); idle(1); end_pkt(1'b0, 1'b0);

        // asynchronous reset while in DATA
        do_sync(); send(8'h3C); send(8'h11); send(8'h22);
        #2 n_rst = 1'b0;
        #1;
        check("async_reset_outputs", 0, int'({pk0, d0, cnt0, st0, dn0, clr0}), 0);
        check("async_reset_outputs", 1, int'({pk1, d1, cnt1, st1, dn1, clr1}), 0);
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;
        send(8'h33); send(8'hC1); end_pkt(1'b0, 1'b1);
        idle(3);

        // recovery after reset
        exp_done(0, 3'b010, 0); exp_done(1, 3'b010, 0);
        do_sync(); send(8'h96); send(8'h05); send(8'hA8); end_pkt(1'b1, 1'b0);
        idle(3);

        for (int i = 0; i < 2; i++) begin
            check("stores_outstanding", i, exp_store[i].size(), 0);
            check("dones_outstanding", i, exp_pkt[i].size(), 0);
            check("crc_clear_pulses", i, clr_seen[i], syncs);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_packet_ctrl.md
RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 64, max DATA payload bytes accepted (1..1024).
REQ-002 SHALL have derived localparam CNT_W, $clog2(MAX_PAYLOAD+1), width of the byte count.
REQ-003 SHALL have port clk  input  1  single clock; all logic posedge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sync_byte  input  1  one-cycle pulse: SYNC detected, packet starts.
REQ-006 SHALL have port byte_valid  input  1  one-cycle pulse: packet_in holds a new byte.
REQ-007 SHALL have port packet_in  input  8  received byte.
REQ-008 SHALL have port eop  input  1  one-cycle pulse: end of packet.
REQ-009 SHALL have port crc5_ok  input  1  token CRC5 good; sampled on eop only.
REQ-010 SHALL have port crc16_ok  input  1  data CRC16 good; sampled on eop only.
REQ-011 SHALL have port crc_clear  output  1  one-cycle pulse clearing the CRC engines.
REQ-012 SHALL have port rx_packet  output  3  packet class: 000 ACK/idle, 001 OUT, 010 IN, 011 error, 100 DATA, 101 NAK, 110 STALL.
REQ-013 SHALL have port rx_data  output  8  payload byte, valid with store_rx_data.
REQ-014 SHALL have port store_rx_data  output  1  one-cycle pulse: push rx_data to the FIFO.
REQ-015 SHALL have port rx_data_count  output  CNT_W  payload bytes stored in the current packet.
REQ-016 SHALL have port rx_done  output  1  one-cycle pulse: packet finished, rx_packet final.

Function
REQ-017 States SHALL be IDLE, PID, TOKEN1, TOKEN2, TOK_EOP, HSK_EOP, DATA, ERR_WAIT.
REQ-018 Every output SHALL be registered; all responses appear the cycle after the triggering input.
REQ-019 sync_byte in any state SHALL pulse crc_clear, zero rx_data_count, empty the delay buffer and enter PID (resync aborts the current packet with no rx_done).
REQ-020 In PID, the byte_valid byte SHALL fail if packet_in[7:4] != ~packet_in[3:0], going to ERR_WAIT.
REQ-021 PID decode: 8'h3C/8'hB4 -> DATA, rx_packet=100; 8'h1E -> TOKEN1, 001; 8'h96 -> TOKEN1, 010; 8'h2D -> HSK_EOP, 000; 8'hA5 -> HSK_EOP, 101; 8'hE1 -> HSK_EOP, 110; other well-formed PID -> ERR_WAIT.
REQ-022 TOKEN1 -> TOKEN2 -> TOK_EOP SHALL each advance on byte_valid.
REQ-023 TOK_EOP on eop: crc5_ok=1 -> IDLE with rx_done; crc5_ok=0 -> rx_packet=011, IDLE, rx_done.
REQ-024 HSK_EOP on eop SHALL return to IDLE with rx_done.
REQ-025 eop in PID, TOKEN1, TOKEN2, or byte_valid in TOK_EOP/HSK_EOP, SHALL set rx_packet=011, pulse rx_done, and enter IDLE (eop) or ERR_WAIT (byte).
REQ-026 DATA SHALL pass bytes through a 2-entry delay buffer; a byte arriving with the buffer full pushes out the oldest as rx_data with store_rx_data and rx_data_count+1.
REQ-027 On eop in DATA, the 2 buffered bytes (CRC16) SHALL be discarded; a buffer holding fewer than 2 bytes or crc16_ok=0 sets rx_packet=011; then IDLE with rx_done.
REQ-028 A push that would make rx_data_count exceed MAX_PAYLOAD SHALL be suppressed, set rx_packet=011 and enter ERR_WAIT.
REQ-029 ERR_WAIT SHALL ignore bytes, keep rx_packet=011, and on eop pulse rx_done and enter IDLE.
REQ-030 byte_valid and eop in the same cycle: the byte SHALL be processed first, then eop evaluated on the updated state.
REQ-031 rx_packet and rx_data_count SHALL hold their final values in IDLE until the next sync_byte.

Reset
REQ-032 n_rst low SHALL immediately force state IDLE, rx_packet=000, rx_data=8'h00, rx_data_count=0, delay buffer empty, and every pulse output 0.
REQ-033 Reset mid-packet SHALL drop the packet without rx_done or store_rx_data.

Structure
REQ-034 Package usb_rx_pkg SHALL hold the PID byte constants, the rx_packet encoding typedef and the state typedef.
REQ-035 The 2-entry delay buffer SHALL be sub-module rx_byte_delay (push, flush, out, out_valid, level).

Verification
REQ-036 sync; bytes 1E,05,A8; eop, crc5_ok=1 -> rx_packet=001, one rx_done, no store_rx_data.
REQ-037 sync; 3C,11,22,33,C1,C2; eop, crc16_ok=1 -> stores 11,22,33 in order, rx_data_count=3, rx_packet=100.
REQ-038 MAX_PAYLOAD=2; sync; B4,01,02,03,C1,C2 -> stores 01,02, then rx_packet=011; rx_done only at eop.
REQ-039 sync; byte 3D (bad complement) -> ERR_WAIT; further bytes ignored; eop -> rx_packet=011, rx_done.
REQ-040 sync; 3C,AA, then sync mid-packet; 2D; eop -> crc_clear twice, no store, rx_packet=000, one rx_done.
REQ-041 n_rst low during DATA after 3 bytes -> all outputs reset in the same cycle; no store_rx_data after release.
